// File: rtl/pulpino_ext_mailbox.sv
// PULPino-side endpoint of the CW305 host mailbox: synchronises host bytes into
// crypto_clk, exposes them through a 4-register APB slave and returns bytes to the host.
module pulpino_ext_mailbox #(
  parameter int pAPB_ADDR_WIDTH = 12
) (
  input  logic                       crypto_clk,
  input  logic                       reset_i,
  input  logic [7:0]                 I_ext_data,
  input  logic [7:0]                 I_ext_flags,
  output logic [7:0]                 O_pulpino_data,
  output logic [7:0]                 O_pulpino_flags,
  input  logic [pAPB_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [31:0]                PWDATA,
  output logic [31:0]                PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic                       irq_o
);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SETUP = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_t;

  localparam logic [1:0] REG_RX_DATA = 2'd0;
  localparam logic [1:0] REG_TX_DATA = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  // Synchroniser stages: toggles get a third flop so edges can be detected.
  logic [1:0] tgl_s1, tgl_s2, tgl_s3;
  logic [7:0] data_s1, data_s2;
  logic [5:0] user_s1, user_s2;

  logic       rx_valid;
  logic       rx_overrun;
  logic [7:0] rx_data;
  logic       ack_tgl;
  logic       req_tgl;
  logic       ack_ref;
  logic [7:0] tx_data;
  logic [7:0] ctrl;
  logic       irq_q;
  tx_state_t  tx_state;

  logic       access;
  logic [1:0] reg_sel;
  logic       rd_rx;
  logic       wr_tx;
  logic       wr_status;
  logic       wr_ctrl;
  logic       rx_req;
  logic       tx_busy;
  logic       unused_bits;

  // APB handshake: an access completes on any edge where PSEL & PENABLE are high;
  // PREADY is constant 1, so every access finishes in its first access cycle and
  // PRDATA/PSLVERR are valid combinationally during that cycle.
  assign access    = PSEL & PENABLE;
  assign reg_sel   = PADDR[3:2];
  assign rd_rx     = access & ~PWRITE & (reg_sel == REG_RX_DATA);
  assign wr_tx     = access &  PWRITE & (reg_sel == REG_TX_DATA);
  assign wr_status = access &  PWRITE & (reg_sel == REG_STATUS);
  assign wr_ctrl   = access &  PWRITE & (reg_sel == REG_CTRL);

  assign rx_req  = tgl_s2[0] ^ tgl_s3[0];
  assign tx_busy = (tx_state != TX_IDLE);

  assign unused_bits = ^{PADDR[pAPB_ADDR_WIDTH-1:4], PADDR[1:0], PWDATA[31:8]};

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      tgl_s1  <= 2'b00;
      tgl_s2  <= 2'b00;
      tgl_s3  <= 2'b00;
      data_s1 <= 8'h00;
      data_s2 <= 8'h00;
      user_s1 <= 6'h00;
      user_s2 <= 6'h00;
    end else begin
      tgl_s1  <= I_ext_flags[1:0];
      tgl_s2  <= tgl_s1;
      tgl_s3  <= tgl_s2;
      data_s1 <= I_ext_data;
      data_s2 <= data_s1;
      user_s1 <= I_ext_flags[7:2];
      user_s2 <= user_s1;
    end
  end

  // RX path. A read colliding with a new request leaves the new byte pending
  // and is not an overrun, because the old byte was just consumed.
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_data    <= 8'h00;
      ack_tgl    <= 1'b0;
    end else begin
      if (wr_status && PWDATA[2]) begin
        rx_overrun <= 1'b0;
      end
      if (rx_req) begin
        rx_data  <= data_s2;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_rx) begin
          rx_overrun <= 1'b1;
        end
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end
      if (rd_rx && rx_valid) begin
        ack_tgl <= ~ack_tgl;
      end
    end
  end

  // TX FSM. SETUP delays the request toggle by one cycle so the data byte is
  // already stable at the host when it sees the toggle.
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      tx_state <= TX_IDLE;
      tx_data  <= 8'h00;
      req_tgl  <= 1'b0;
      ack_ref  <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (wr_tx) begin
            tx_data  <= PWDATA[7:0];
            tx_state <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          req_tgl  <= ~req_tgl;
          ack_ref  <= tgl_s2[1];
          tx_state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tgl_s2[1] != ack_ref) begin
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      ctrl  <= 8'h00;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= PWDATA[7:0];
      end
      irq_q <= (rx_valid & ctrl[0]) | (~tx_busy & ctrl[1]);
    end
  end

  always_comb begin
    PRDATA = 32'h0;
    if (PSEL && !PWRITE) begin
      case (reg_sel)
        REG_RX_DATA: PRDATA = {23'b0, rx_valid, rx_data};
        REG_STATUS:  PRDATA = {16'b0, user_s2, 7'b0, rx_overrun, tx_busy, rx_valid};
        REG_CTRL:    PRDATA = {24'b0, ctrl};
        default:     PRDATA = 32'h0;
      endcase
    end
  end

  assign PSLVERR         = wr_tx & tx_busy;
  assign PREADY          = 1'b1;
  assign O_pulpino_data  = tx_data;
  assign O_pulpino_flags = {ctrl[7:2], ack_tgl, req_tgl};
  assign irq_o           = irq_q;

endmodule

// File: tb/tb_pulpino_ext_mailbox.sv
// Directed bench for pulpino_ext_mailbox: APB responses go through an expected
// queue checked by a monitor; pin-level timing is checked against fixed cycle points.
module tb_pulpino_ext_mailbox;

  logic        crypto_clk;
  logic        reset_i;
  logic [7:0]  I_ext_data;
  logic [7:0]  I_ext_flags;
  logic [7:0]  O_pulpino_data;
  logic [7:0]  O_pulpino_flags;
  logic [11:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        irq_o;

  logic [32:0] exp_q[$];
  int          n_cmp;
  int          n_bad;

  pulpino_ext_mailbox #(.pAPB_ADDR_WIDTH(12)) dut (
    .crypto_clk      (crypto_clk),
    .reset_i         (reset_i),
    .I_ext_data      (I_ext_data),
    .I_ext_flags     (I_ext_flags),
    .O_pulpino_data  (O_pulpino_data),
    .O_pulpino_flags (O_pulpino_flags),
    .PADDR           (PADDR),
    .PSEL            (PSEL),
    .PENABLE         (PENABLE),
    .PWRITE          (PWRITE),
    .PWDATA          (PWDATA),
    .PRDATA          (PRDATA),
    .PREADY          (PREADY),
    .PSLVERR         (PSLVERR),
    .irq_o           (irq_o)
  );

  // clock / reset
  initial crypto_clk = 1'b0;
  always #5 crypto_clk = ~crypto_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // driver tasks; every task returns 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge crypto_clk);
    #1;
  endtask

  task automatic apb_rd(input logic [11:0] a, input logic [31:0] exp);
    exp_q.push_back({1'b0, exp});
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    tick(1);
    PENABLE = 1'b1;
    tick(1);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic exp_err);
    exp_q.push_back({exp_err, 32'h0});
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    tick(1);
    PENABLE = 1'b1;
    tick(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic host_send(input logic [7:0] d);
    I_ext_data = d;
    tick(2);
    I_ext_flags[0] = ~I_ext_flags[0];
  endtask

  // scoreboard monitor: one expected entry per completed APB access
  always @(negedge crypto_clk) begin
    if (PSEL && PENABLE) begin
      logic [32:0] got;
      logic [32:0] e;
      got = PWRITE ? {PSLVERR, 32'h0} : {PSLVERR, PRDATA};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL apb_unexpected: got 0x%0h with empty queue at %0t", got, $time);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL apb_%s addr 0x%0h: got 0x%0h expected 0x%0h at %0t",
                   PWRITE ? "wr" : "rd", PADDR, got, e, $time);
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_i = 1'b1; I_ext_data = 8'h00; I_ext_flags = 8'h00;
    PADDR = 12'h0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = 32'h0;
    tick(2);
    reset_i = 1'b0;

    // reset state
    check("rst_data",   {24'h0, O_pulpino_data}, 32'h0);
    check("rst_flags",  {24'h0, O_pulpino_flags}, 32'h0);
    check("rst_irq",    {31'h0, irq_o}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_slverr", {31'h0, PSLVERR}, 32'h0);
    check("rst_pready", {31'h0, PREADY}, 32'h1);
    apb_rd(12'h8, 32'h0);

    // RX: toggle at edge k, read's setup edge is k+2
    host_send(8'hA5);
    tick(2);
    check("rx_ack_before", {24'h0, O_pulpino_flags}, 32'h00);
    apb_rd(12'h0, 32'h1A5);
    check("rx_ack_after", {24'h0, O_pulpino_flags}, 32'h02);
    apb_rd(12'h0, 32'h0A5);

    // TX with tx_irq_en
    apb_wr(12'hC, 32'h2, 1'b0);
    tick(1);
    check("irq_idle", {31'h0, irq_o}, 32'h1);
    apb_wr(12'h4, 32'h3C, 1'b0);
    check("tx_data",   {24'h0, O_pulpino_data}, 32'h3C);
    check("tx_flag_n", {24'h0, O_pulpino_flags}, 32'h02);
    check("irq_n",     {31'h0, irq_o}, 32'h1);
    tick(1);
    check("tx_flag_n1", {24'h0, O_pulpino_flags}, 32'h03);
    check("irq_n1",     {31'h0, irq_o}, 32'h0);
    apb_wr(12'h4, 32'h55, 1'b1);
    check("tx_data_kept", {24'h0, O_pulpino_data}, 32'h3C);
    apb_rd(12'h8, 32'h2);
    I_ext_flags[1] = 1'b1;
    tick(2);
    check("irq_ack_k1", {31'h0, irq_o}, 32'h0);
    tick(1);
    check("irq_ack_k2", {31'h0, irq_o}, 32'h0);
    tick(1);
    check("irq_ack_k3", {31'h0, irq_o}, 32'h1);
    apb_rd(12'h8, 32'h0);

    // overrun; first read samples one edge before rx_valid rises
    host_send(8'h11);
    tick(1);
    apb_rd(12'h8, 32'h0);
    host_send(8'h22);
    tick(3);
    apb_rd(12'h8, 32'h5);
    apb_rd(12'h0, 32'h122);
    check("ovr_ack", {24'h0, O_pulpino_flags}, 32'h01);
    apb_rd(12'h8, 32'h4);
    apb_wr(12'h8, 32'h4, 1'b0);
    apb_rd(12'h8, 32'h0);

    // collision: RX_DATA access edge coincides with rx_req
    host_send(8'h33);
    tick(3);
    host_send(8'h44);
    tick(1);
    apb_rd(12'h0, 32'h133);
    check("col_ack", {24'h0, O_pulpino_flags}, 32'h03);
    apb_rd(12'h8, 32'h1);
    apb_rd(12'h0, 32'h144);
    check("col_ack2", {24'h0, O_pulpino_flags}, 32'h01);

    // user bits, CTRL, write-only/read-only registers
    I_ext_flags[7:2] = 6'b101101;
    tick(2);
    apb_rd(12'h8, 32'hB400);
    apb_wr(12'hC, 32'hB4, 1'b0);
    check("ctrl_flags", {24'h0, O_pulpino_flags}, 32'hB5);
    apb_rd(12'hC, 32'hB4);
    apb_rd(12'h4, 32'h0);
    apb_wr(12'h0, 32'hFF, 1'b0);
    apb_rd(12'h0, 32'h044);

    // rx irq rises one cycle after rx_valid
    apb_wr(12'hC, 32'h1, 1'b0);
    tick(1);
    check("rxirq_idle", {31'h0, irq_o}, 32'h0);
    host_send(8'h5A);
    tick(3);
    check("rxirq_k2", {31'h0, irq_o}, 32'h0);
    tick(1);
    check("rxirq_k3", {31'h0, irq_o}, 32'h1);
    apb_rd(12'h0, 32'h15A);
    check("rxirq_rd", {31'h0, irq_o}, 32'h1);
    tick(1);
    check("rxirq_clr", {31'h0, irq_o}, 32'h0);
    check("rxirq_flags", {24'h0, O_pulpino_flags}, 32'h03);

    // reset in the middle of a transfer
    apb_wr(12'h4, 32'h77, 1'b0);
    tick(1);
    check("mid_flag", {24'h0, O_pulpino_flags}, 32'h02);
    reset_i = 1'b1; I_ext_flags = 8'h00; I_ext_data = 8'h00;
    tick(1);
    reset_i = 1'b0;
    check("mid_rst_data",  {24'h0, O_pulpino_data}, 32'h0);
    check("mid_rst_flags", {24'h0, O_pulpino_flags}, 32'h0);
    check("mid_rst_irq",   {31'h0, irq_o}, 32'h0);
    apb_rd(12'h8, 32'h0);

    tick(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
